// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table probe: sweep FSM states, table
// geometry and a popcount helper for the minterm count.
package truth_table_pkg;

    localparam int N_IN       = 4;
    localparam int N_ROWS     = 16;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Number of ones in a 16-bit table (0..16).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter: counts the idle cycles a row is held before its
// response is sampled. done is high while the count is zero.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down to zero while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/truth_table_probe.sv
// Truth-table probe: walks all 16 input rows of a 4-input function, holds
// each row SETTLE+1 cycles, samples the response on the last edge of the
// window and presents the measured table with its minterm count and a
// comparison against a reference table.
//
// Result handshake: tt_valid is high for the whole HOLD state and tt, ones
// and match are stable while it is high; the result is consumed on a rising
// edge where tt_valid && tt_ready, after which the FSM returns to IDLE. The
// values stay readable in IDLE until the next accepted start.
module truth_table_probe
    import truth_table_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        x_1,
    output logic        x_2,
    output logic        x_3,
    output logic        x_4,
    input  logic        s,
    input  logic [15:0] expect_tt,
    output logic        busy,
    output logic        tt_valid,
    input  logic        tt_ready,
    output logic [15:0] tt,
    output logic [4:0]  ones,
    output logic        match,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] SETTLE_VAL = 4'(SETTLE);
    localparam logic [3:0] LAST_ROW   = 4'(N_ROWS - 1);

    state_t      state_q, state_d;
    logic [3:0]  row_q;
    logic [15:0] tt_q;
    logic [4:0]  ones_q;
    logic        match_q;

    logic        start_take;
    logic        abort_take;
    logic        row_step;
    logic        last_row;
    logic        settle_done;
    logic [15:0] tt_sampled;

    settle_timer #(.W(4)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_take | row_step),
        .en       (state_q == DRIVE),
        .load_val (SETTLE_VAL),
        .done     (settle_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; abort beats the final sample.
    always_comb begin
        state_d    = state_q;
        start_take = 1'b0;
        abort_take = 1'b0;
        row_step   = 1'b0;
        last_row   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_take = 1'b1;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    abort_take = 1'b1;
                    state_d    = IDLE;
                end else if (settle_done) begin
                    row_step = 1'b1;
                    if (row_q == LAST_ROW) begin
                        last_row = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current table with the response of the active row merged in.
    always_comb begin
        tt_sampled        = tt_q;
        tt_sampled[row_q] = s;
    end

    // Row index, measured table and summary results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
        end else if (start_take || abort_take) begin
            row_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
        end else if (row_step) begin
            tt_q  <= tt_sampled;
            row_q <= row_q + 1'b1;
            if (last_row) begin
                ones_q  <= popcount16(tt_sampled);
                match_q <= (tt_sampled == expect_tt);
            end
        end
    end

    assign {x_1, x_2, x_3, x_4} = (state_q == DRIVE) ? row_q : 4'b0000;
    assign busy      = (state_q == DRIVE);
    assign tt_valid  = (state_q == HOLD);
    assign tt        = tt_q;
    assign ones      = ones_q;
    assign match     = match_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe: one instance at SETTLE=2 driven by a table
// model, one at SETTLE=0 driven by a 4-input XOR. Expected results are
// queued when a sweep is started and checked by monitors on each handshake.
module tb_truth_table_probe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT at SETTLE=2 ----------------
    logic        start, abort, tt_ready, s;
    logic [15:0] expect_tt, model_tt;
    logic        x_1, x_2, x_3, x_4, busy, tt_valid, match;
    logic [15:0] tt;
    logic [4:0]  ones;
    logic [1:0]  dbg_state;
    logic [3:0]  xv;

    assign xv = {x_1, x_2, x_3, x_4};
    assign s  = model_tt[xv];

    truth_table_probe #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4), .s(s),
        .expect_tt(expect_tt), .busy(busy), .tt_valid(tt_valid),
        .tt_ready(tt_ready), .tt(tt), .ones(ones), .match(match),
        .dbg_state(dbg_state)
    );

    // ---------------- DUT at SETTLE=0 ----------------
    logic        z_start, z_abort, z_ready, z_s;
    logic [15:0] z_expect;
    logic        z_x1, z_x2, z_x3, z_x4, z_busy, z_valid, z_match;
    logic [15:0] z_tt;
    logic [4:0]  z_ones;
    logic [1:0]  z_state;

    assign z_s = z_x1 ^ z_x2 ^ z_x3 ^ z_x4;

    truth_table_probe #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort),
        .x_1(z_x1), .x_2(z_x2), .x_3(z_x3), .x_4(z_x4), .s(z_s),
        .expect_tt(z_expect), .busy(z_busy), .tt_valid(z_valid),
        .tt_ready(z_ready), .tt(z_tt), .ones(z_ones), .match(z_match),
        .dbg_state(z_state)
    );

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_pass = 0;
    logic [21:0] exp_q[$];   // {tt, ones, match}
    logic [21:0] exp0_q[$];
    int st_cyc = 0;
    int st0_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor for SETTLE=2: latency on tt_valid rise, result on handshake.
    logic        prev_v = 1'b0;
    logic [21:0] e2;
    always @(negedge clk) begin
        #2;
        if (tt_valid && !prev_v) check("latency_s2", cyc - st_cyc, 48);
        if (tt_valid && tt_ready) begin
            if (exp_q.size() == 0) check("unexpected_result_s2", 1, 0);
            else begin
                e2 = exp_q.pop_front();
                check("tt_s2", tt, e2[21:6]);
                check("ones_s2", ones, e2[5:1]);
                check("match_s2", match, e2[0]);
            end
        end
        prev_v = tt_valid;
    end

    // Monitor for SETTLE=0.
    logic        prev_z = 1'b0;
    logic [21:0] e0;
    always @(negedge clk) begin
        #2;
        if (z_valid && !prev_z) check("latency_s0", cyc - st0_cyc, 16);
        if (z_valid && z_ready) begin
            if (exp0_q.size() == 0) check("unexpected_result_s0", 1, 0);
            else begin
                e0 = exp0_q.pop_front();
                check("tt_s0", z_tt, e0[21:6]);
                check("ones_s0", z_ones, e0[5:1]);
                check("match_s0", z_match, e0[0]);
            end
        end
        prev_z = z_valid;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        st_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((dbg_state != 2'd0) && (n < lim)) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) check("timeout_idle", 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, tt_valid, 0);
        check({tag, "_x"}, xv, 0);
        check({tag, "_tt"}, tt, 0);
        check({tag, "_ones"}, ones, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int n;
        start = 0; abort = 0; tt_ready = 1;
        expect_tt = 16'hF547; model_tt = 16'hF547;
        z_start = 0; z_abort = 0; z_ready = 1; z_expect = 16'h6996;

        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Matching sweep: F547 has 10 ones.
        exp_q.push_back({16'hF547, 5'd10, 1'b1});
        pulse_start();
        check("busy_in_drive", busy, 1);
        check("row0_first", xv, 0);
        wait_idle(200);
        check("idle_keeps_tt", tt, 16'hF547);
        check("idle_keeps_ones", ones, 10);

        // Mismatching reference; tt cleared on start.
        expect_tt = 16'hF546;
        exp_q.push_back({16'hF547, 5'd10, 1'b0});
        pulse_start();
        check("tt_cleared_on_start", tt, 0);
        wait_idle(200);

        // Abort at cycle 20, then a normal sweep.
        pulse_start();
        while (cyc < st_cyc + 19) @(negedge clk);
        check("partial_tt_before_abort", tt[2:0], 3'b111);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_all_zero("abort");
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (tt_valid) seen = 1;
        end
        check("no_valid_after_abort", seen, 0);
        exp_q.push_back({16'hF547, 5'd10, 1'b0});
        pulse_start();
        wait_idle(200);

        // Abort ignored in IDLE; back-pressure in HOLD with stray start/abort.
        expect_tt = 16'hF547;
        exp_q.push_back({16'hF547, 5'd10, 1'b1});
        tt_ready = 1'b0;
        abort = 1'b1;
        pulse_start();
        abort = 1'b0;
        check("abort_ignored_idle", busy, 1);
        n = 0;
        while (!tt_valid && n < 100) begin @(negedge clk); n++; end
        check("hold_reached", tt_valid, 1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            abort = (i == 6);
            @(negedge clk);
            check("hold_valid_stable", tt_valid, 1);
            check("hold_tt_stable", tt, 16'hF547);
        end
        start = 1'b1;
        tt_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_after_handshake", dbg_state, 0);
        check("start_ignored_at_handshake", busy, 0);

        // Reset during row 7.
        pulse_start();
        n = 0;
        while (xv != 4'd7 && n < 100) begin @(negedge clk); n++; end
        check("reached_row7", xv, 7);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back({16'hF547, 5'd10, 1'b1});
        pulse_start();
        check("restart_row0", xv, 0);
        wait_idle(200);

        // SETTLE=0 instance: XOR function.
        exp0_q.push_back({16'h6996, 5'd8, 1'b1});
        z_start = 1'b1;
        @(negedge clk);
        st0_cyc = cyc;
        z_start = 1'b0;
        n = 0;
        while (z_state != 2'd0 && n < 100) begin @(negedge clk); n++; end
        check("s0_done", z_state, 0);

        repeat (3) @(negedge clk);
        check("s2_queue_drained", exp_q.size(), 0);
        check("s0_queue_drained", exp0_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
